// File: rtl/data_mem_responder_if.sv
// Cache <-> data-memory request/response bundle.
// Handshake: the cache raises MemRead_wire or MemWrite_wire with a stable
// address (and write data) and holds them until it sees the one-cycle
// MemValid_wire strobe. Busy is high from accept until the cycle after that
// strobe. Requests that arrive while Busy is high are dropped, not queued.
interface data_mem_responder_if;
  logic        MemRead_wire;
  logic        MemWrite_wire;
  logic [31:0] MemAddress_wire;
  logic [31:0] MemWriteData_wire;
  logic [31:0] Datamem_wire;
  logic        MemValid_wire;
  logic        Busy;

  modport master (
    output MemRead_wire, MemWrite_wire, MemAddress_wire, MemWriteData_wire,
    input  Datamem_wire, MemValid_wire, Busy
  );

  modport slave (
    input  MemRead_wire, MemWrite_wire, MemAddress_wire, MemWriteData_wire,
    output Datamem_wire, MemValid_wire, Busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one read/write from the cache miss path,
// waits a fixed latency, performs the word access on the backing RAM and
// returns the data with a single-cycle MemValid_wire pulse.
module data_mem_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int DEPTH   = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  ram_we;
  logic [31:0]           ram_q [DEPTH];

  // Byte offset and the bits above the RAM index only alias; they are never decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.MemAddress_wire[31:ADDR_WIDTH+2], bus.MemAddress_wire[1:0]};

  // Next-state, latency counter and access decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    ram_we      = 1'b0;
    case (state_q)
      IDLE: begin
        // Write has priority; a simultaneous read is discarded.
        if (bus.MemWrite_wire) begin
          idx_d   = bus.MemAddress_wire[ADDR_WIDTH+1:2];
          wdata_d = bus.MemWriteData_wire;
          cnt_d   = CNT_W'(WRITE_LATENCY - 1);
          state_d = WR_WAIT;
        end else if (bus.MemRead_wire) begin
          idx_d   = bus.MemAddress_wire[ADDR_WIDTH+1:2];
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          resp_data_d = ram_q[idx_q];
          state_d     = RESP;
        end
      end
      WR_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ram_we      = 1'b1;
          resp_data_d = wdata_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control/state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Backing RAM: not reset; a reset on the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (ram_we && rst) begin
      ram_q[idx_q] <= wdata_q;
    end
  end

  // Outputs decode only registered state, so there is no input-to-output path.
  always_comb begin
    bus.MemValid_wire = (state_q == RESP);
    bus.Datamem_wire  = (state_q == RESP) ? resp_data_q : 32'h0;
    bus.Busy          = (state_q != IDLE);
    dbg_state         = state_q;
  end

endmodule
